// File: rtl/mux_rr_arbiter_if.sv
// Handshake bundle between requesters, the round-robin output stage and the downstream sink.
// The lock vector exists only when MUX_ARB_LOCK_EN is defined.
interface mux_rr_arbiter_if #(
  parameter int N = 4
);
  logic [3:0]   req_valid;
  logic [N-1:0] in [3:0];
  logic         aux;
  logic [3:0]   req_ready;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic         out_aux;
  logic [1:0]   out_sel;
`ifdef MUX_ARB_LOCK_EN
  logic [3:0]   lock;
`endif

  modport master (
    output req_valid, in, aux, out_ready,
`ifdef MUX_ARB_LOCK_EN
    output lock,
`endif
    input  req_ready, out_valid, out_data, out_aux, out_sel
  );

  modport slave (
    input  req_valid, in, aux, out_ready,
`ifdef MUX_ARB_LOCK_EN
    input  lock,
`endif
    output req_ready, out_valid, out_data, out_aux, out_sel
  );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Four-way round-robin arbiter feeding a single registered output word.
// Define MUX_ARB_LOCK_EN to add per-requester lock that pins the grant to one owner.
//
// state | meaning
// EMPTY | no word held, out_valid=0, any valid requester may load
// FULL  | word held in out_data/out_sel/out_aux, reload only when out_ready=1
module mux_rr_arbiter #(
  parameter int N = 4
) (
  input logic             clk,
  input logic             rst_n,
  mux_rr_arbiter_if.slave bus
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t     state;
  logic [1:0] ptr;
  logic [1:0] g;
  logic       found;
  logic       load_en;
  logic       transfer;
  logic [3:0] grant;
`ifdef MUX_ARB_LOCK_EN
  logic       locked;
  logic [1:0] lock_owner;
`endif

  assign load_en       = (state == EMPTY) | bus.out_ready;
  assign bus.out_valid = (state == FULL);

  always_comb begin : winner
    logic [1:0] idx;
    found = 1'b0;
    g     = ptr;
    idx   = ptr;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        g     = idx;
      end
    end
`ifdef MUX_ARB_LOCK_EN
    // A held lock overrides the rotating search entirely.
    if (locked) begin
      found = bus.req_valid[lock_owner];
      g     = lock_owner;
    end
`endif
  end

  always_comb begin
    grant = 4'b0000;
    if (found && load_en && rst_n) grant[g] = 1'b1;
  end

  assign bus.req_ready = grant;
  assign transfer      = |grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= EMPTY;
      ptr          <= 2'd0;
      bus.out_data <= {N{1'b0}};
      bus.out_aux  <= 1'b0;
      bus.out_sel  <= 2'd0;
`ifdef MUX_ARB_LOCK_EN
      locked       <= 1'b0;
      lock_owner   <= 2'd0;
`endif
    end else begin
      if (transfer) begin
        state        <= FULL;
        bus.out_data <= bus.in[g];
        bus.out_sel  <= g;
        bus.out_aux  <= (g == 2'd3) ? bus.aux : 1'b0;
`ifdef MUX_ARB_LOCK_EN
        if (locked) begin
          if (!bus.lock[g]) begin
            locked <= 1'b0;
            ptr    <= g + 2'd1;
          end
        end else begin
          ptr <= g + 2'd1;
          if (bus.lock[g]) begin
            locked     <= 1'b1;
            lock_owner <= g;
          end
        end
`else
        ptr <= g + 2'd1;
`endif
      end else if (bus.out_ready && state == FULL) begin
        state <= EMPTY;
      end
    end
  end
endmodule
